// File: rtl/dnn_argmax_fix.sv
// Argmax classifier for the MNIST engine's output logits.
// Captures all logits on start, scans one per cycle, then holds the result under valid/ready.
module dnn_argmax_fix #(
  parameter int DATA_WIDTH  = 12,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] logits,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             class_max,
  output logic [DATA_WIDTH-1:0]             margin
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   state;
  logic signed [DATA_WIDTH-1:0] lreg [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best;
  logic signed [DATA_WIDTH-1:0] second;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic [IDX_WIDTH-1:0]         cnt;

  logic signed [DATA_WIDTH-1:0] cur;
  logic signed [DATA_WIDTH-1:0] best_nx;
  logic signed [DATA_WIDTH-1:0] second_nx;
  logic [IDX_WIDTH-1:0]         idx_nx;
  logic [DATA_WIDTH:0]          diff;

  // Strict > keeps the lowest index on ties; an equal value still lifts second.
  always_comb begin
    cur       = lreg[cnt];
    best_nx   = best;
    second_nx = second;
    idx_nx    = best_idx;
    if (cur > best) begin
      second_nx = best;
      best_nx   = cur;
      idx_nx    = cnt;
    end else if (cur > second) begin
      second_nx = cur;
    end
    diff = {best_nx[DATA_WIDTH-1], best_nx} - {second_nx[DATA_WIDTH-1], second_nx};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      class_idx <= '0;
      class_max <= '0;
      margin    <= '0;
      best      <= '0;
      second    <= '0;
      best_idx  <= '0;
      cnt       <= '0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) lreg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++)
              lreg[i] <= logits[i*DATA_WIDTH +: DATA_WIDTH];
            best     <= logits[DATA_WIDTH-1:0];
            best_idx <= '0;
            second   <= MOST_NEG;
            cnt      <= IDX_WIDTH'(1);
            state    <= SCAN;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          best     <= best_nx;
          second   <= second_nx;
          best_idx <= idx_nx;
          cnt      <= cnt + 1'b1;
          // Outputs take the post-comparison values so the last logit counts.
          if (cnt == LAST) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            class_idx <= idx_nx;
            class_max <= best_nx;
            margin    <= diff[DATA_WIDTH-1:0];
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_argmax_fix.sv
// Self-checking bench for dnn_argmax_fix: directed corner cases plus randomized logit sets
// compared against a plain max/second-max reference.
module tb_dnn_argmax_fix;

  localparam int DW = 12;
  localparam int NC = 10;
  localparam int IW = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [NC*DW-1:0]   logits = '0;
  logic               busy;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [IW-1:0]      class_idx;
  logic [DW-1:0]      class_max;
  logic [DW-1:0]      margin;

  int n_cmp = 0;
  int n_bad = 0;

  dnn_argmax_fix #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .logits    (logits),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .class_max (class_max),
    .margin    (margin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: largest value at its lowest index; second = largest of the remaining entries.
  function automatic void model(input int v[NC], output int idx, output int mx, output int mg);
    int sec;
    mx  = v[0];
    idx = 0;
    for (int i = 1; i < NC; i++)
      if (v[i] > mx) begin
        mx  = v[i];
        idx = i;
      end
    sec = -(1 << (DW - 1));
    for (int i = 0; i < NC; i++)
      if (i != idx && v[i] > sec) sec = v[i];
    mg = mx - sec;
  endfunction

  task automatic load(input int v[NC]);
    for (int i = 0; i < NC; i++) logits[i*DW +: DW] = DW'(v[i]);
  endtask

  task automatic rand_vec(output int v[NC]);
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < NC; i++) begin
      case (mode)
        0:       v[i] = int'($urandom_range(0, 4095)) - 2048;
        1:       v[i] = int'($urandom_range(0, 3)) * 100 - 150;
        default: v[i] = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
      endcase
    end
  endtask

  function automatic int smax();
    return int'($signed(class_max));
  endfunction

  // One full transaction: start, latency, result, optional backpressure, handshake.
  task automatic run(input string tag, input int v[NC], input int hold_cycles);
    int ei, em, eg, lat;
    int junk[NC];
    model(v, ei, em, eg);
    load(v);
    out_ready = (hold_cycles == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rand_vec(junk);
    load(junk);
    check({tag, ".busy"}, int'(busy), 1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, NC);
    check({tag, ".idx"}, int'(class_idx), ei);
    check({tag, ".max"}, smax(), em);
    check({tag, ".margin"}, int'(margin), eg);
    for (int k = 0; k < hold_cycles; k++) begin
      if (k == 3) start = 1'b1;
      rand_vec(junk);
      load(junk);
      @(negedge clk);
      start = 1'b0;
      check({tag, ".hold_valid"}, int'(out_valid), 1);
      check({tag, ".hold_idx"}, int'(class_idx), ei);
      check({tag, ".hold_max"}, smax(), em);
      check({tag, ".hold_margin"}, int'(margin), eg);
    end
    // A start coincident with the handshake edge must be ignored.
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".ack_valid"}, int'(out_valid), 0);
    check({tag, ".ack_busy"}, int'(busy), 0);
    check({tag, ".kept_idx"}, int'(class_idx), ei);
    check({tag, ".kept_margin"}, int'(margin), eg);
  endtask

  initial begin
    int v[NC];
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.valid", int'(out_valid), 0);
    check("rst.idx", int'(class_idx), 0);
    check("rst.max", smax(), 0);
    check("rst.margin", int'(margin), 0);
    rst = 1'b1;
    @(negedge clk);

    run("max7", '{-3, 12, 5, 0, -100, 40, 39, 400, -2048, 2}, 0);
    run("tie", '{-1, -1, -1, 1023, -1, -1, -1, -1, 1023, -1}, 0);
    for (int i = 0; i < NC; i++) v[i] = -2048;
    run("allneg", v, 0);
    v[9] = 2047;
    run("ext9", v, 0);
    run("bp", '{5, 6, 7, -8, 100, 99, 100, 0, 1, 2}, 20);
    run("after_bp", '{-9, -8, -7, -6, -5, -4, -3, -2, -1, 0}, 0);

    // Asynchronous reset partway through a scan.
    load('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.valid", int'(out_valid), 0);
    check("midrst.idx", int'(class_idx), 0);
    check("midrst.max", smax(), 0);
    check("midrst.margin", int'(margin), 0);
    @(negedge clk);
    check("midrst.held_valid", int'(out_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    run("post_rst", '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3}, 0);

    run("b2b_a", '{10, 20, 30, 40, 50, 60, 70, 80, 90, 95}, 0);
    run("b2b_b", '{900, 20, 30, 40, 50, 60, 70, 80, 90, 899}, 0);

    for (int t = 0; t < 40; t++) begin
      rand_vec(v);
      run("rand", v, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dnn_argmax_fix.md
Name: dnn_argmax_fix

Overview:
- Classification stage directly downstream of the fixed-point MNIST inference engine.
- Captures the engine's 10 signed output logits when the engine signals done.
- Scans the logits serially and reports three results: predicted digit (argmax), winning logit value, and confidence margin (best minus second best).
- Results are delivered over a valid/ready handshake to the result consumer (display, UART or scoreboard).

Parameters:
- DATA_WIDTH, 12: width of each signed logit.
- NUM_CLASSES, 10: number of logits scanned; must be at least 2.
- IDX_WIDTH, 4: width of the class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse, driven from the inference engine's done.
- logits  input  NUM_CLASSES x DATA_WIDTH, signed  engine outputs; sampled only on an accepted start.
- busy  output  1  high in SCAN and HOLD.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- class_idx  output  IDX_WIDTH  index of the maximum logit.
- class_max  output  DATA_WIDTH, signed  value of the maximum logit.
- margin  output  DATA_WIDTH, unsigned  best minus second best.

Behaviour:
- Reset (rst low, asynchronous):
  - State returns to IDLE.
  - busy, out_valid, class_idx, class_max, margin and all internal registers clear to 0.
  - Reset asserted mid-SCAN or mid-HOLD aborts the operation; no partial result is ever presented.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - start=1 at a rising edge: copy all logits into an internal register array.
  - Set best=logit[0], best_idx=0, second=most-negative value (-2^(DATA_WIDTH-1)), cnt=1.
  - Go to SCAN.
- SCAN: one comparison per cycle on L = logit[cnt].
  - If L > best (signed, strict): second=best, best=L, best_idx=cnt.
  - Else if L > second: second=L.
  - Ties therefore resolve to the lowest index; a value equal to best updates second, giving margin 0.
  - cnt increments each cycle. On the edge that processes cnt==NUM_CLASSES-1, go to HOLD and register the outputs in the same edge:
    - class_idx=best_idx, class_max=best, margin=best-second.
- Margin arithmetic:
  - Subtraction is computed in DATA_WIDTH+1 bits.
  - The result lies in 0..2^DATA_WIDTH-1, so truncation to DATA_WIDTH unsigned bits is lossless; no saturation is needed.
- Latency: start sampled at edge 0 gives out_valid high after edge NUM_CLASSES-1 (9 cycles with the defaults).
- HOLD:
  - out_valid=1; class_idx, class_max and margin stay stable.
  - On an edge with out_valid && out_ready: return to IDLE, out_valid=0.
  - Result outputs keep their last values after the handshake until the next result.
  - out_ready held high before out_valid does not shorten the latency.
- start outside IDLE is ignored: it does not restart, re-sample or queue.
  - This includes start coincident with the HOLD handshake edge.
  - A new start is accepted no earlier than the cycle after out_valid falls.
- Logit changes after capture do not affect the current result.
- busy equals (state != IDLE), registered.

Test Plan:
- Max at index 7: logits = {0:-3, 1:12, 2:5, 3:0, 4:-100, 5:40, 6:39, 7:400, 8:-2048, 9:2}, out_ready=1 → out_valid rises 9 cycles after the start edge; class_idx=7, class_max=400, margin=360.
- Tie: logits 3 and 8 both 1023, all others -1 → class_idx=3, class_max=1023, margin=0.
- Extremes: all logits -2048 → class_idx=0, class_max=-2048, margin=0. Then logit[9]=2047 with all others -2048 → class_idx=9, margin=4095.
- Backpressure: out_ready=0 for 20 cycles after out_valid → outputs stable and out_valid held. A start pulse during the hold, with different logits, is ignored. out_ready=1 → one handshake, then IDLE; the next start yields the new result.
- Reset mid-scan: rst low at cycle 4 after start → busy=0, out_valid=0 and all outputs 0 immediately (asynchronous). After release, a new start produces the correct result with the standard latency.
- Back-to-back: two starts with different logit sets, each acknowledged on the first out_valid cycle → two correct results, with no start lost when it arrives in IDLE.
